// File: rtl/mem_if_pkg.sv
// mem_if_pkg: shared types and constants for the data-memory responder
package mem_if_pkg;
  localparam int WORD_BYTES = 4;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} resp_state_t;
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;
endpackage

// File: rtl/data_memory_responder_if.sv
// data_memory_responder_if: valid/ready request and response channels of the data-memory port
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder_byte_enable_ram.sv
// byte_enable_ram: single-port word RAM, synchronous byte-enabled write, combinational read
module byte_enable_ram #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH_WORDS];
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  assign rdata = mem[addr];
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: one-at-a-time load/store responder with programmable access latency
module data_memory_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input logic               clock,
  input logic               reset_n,
  data_memory_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int OW = $clog2(WORD_BYTES);
  resp_state_t state, next;
  mem_req_t    req_q;
  logic [3:0]  cnt;
  logic [31:0] rdata_q, ram_rdata;
  logic        err_q, err, access, we;
  assign err = (|req_q.addr[OW-1:0]) || (req_q.addr[31:2] >= 30'(DEPTH_WORDS));
  byte_enable_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk(clock), .we(we), .addr(req_q.addr[AW+1:2]), .be(req_q.be),
    .wdata(req_q.wdata), .rdata(ram_rdata)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next;
      if (state == IDLE && bus.req_valid) begin
        req_q <= '{bus.req_write, bus.req_addr, bus.req_wdata, bus.req_be};
        cnt   <= 4'(LATENCY - 1);
      end else if (state == BUSY && cnt != 0) cnt <= cnt - 4'd1;
      if (access) begin
        rdata_q <= (err || req_q.write) ? '0 : ram_rdata;
        err_q   <= err;
      end else if (state == RESP && bus.resp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  always_comb begin
    next = state;
    if (state == IDLE && bus.req_valid) next = BUSY;
    if (access) next = RESP;
    if (state == RESP && bus.resp_ready) next = IDLE;
  end
  // stores to bad addresses still take the full latency but never touch the array
  always_comb begin
    access         = state == BUSY && cnt == 0;
    we             = access && req_q.write && !err;
    bus.req_ready  = state == IDLE;
    bus.resp_valid = state == RESP;
    bus.resp_rdata = rdata_q;
    bus.resp_error = err_q;
  end
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: directed vectors and multi-cycle sequences over four latency configurations
module tb_data_memory_responder;
  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;
  logic        clk = 1'b0;
  logic [3:0]  rst_n, req_valid, req_write, resp_ready, req_ready, resp_valid, resp_error;
  logic [31:0] req_addr [4];
  logic [31:0] req_wdata [4];
  logic [31:0] resp_rdata [4];
  logic [3:0]  req_be [4];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int LAT = g == 0 ? 2 : g == 1 ? 3 : g == 2 ? 1 : 15;
    data_memory_responder_if bus ();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_write  = req_write[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.req_be     = req_be[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_rdata[g]  = bus.resp_rdata;
    assign resp_error[g]  = bus.resp_error;
    data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
      .clock(clk), .reset_n(rst_n[g]), .bus(bus)
    );
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // issues one request and returns once resp_valid is seen (left in RESP)
  task automatic op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
    chk("req_ready_before_op", 32'(req_ready[k]), 32'd1);
    req_valid[k] = 1'b1;
    req_write[k] = w;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
    tick;
    req_valid[k] = 1'b0;
    lat = 0;
    while (!resp_valid[k] && lat < 40) begin
      tick;
      lat++;
    end
    rd = resp_rdata[k];
    er = resp_error[k];
  endtask
  task automatic ack(input int k);
    resp_ready[k] = 1'b1;
    tick;
    resp_ready[k] = 1'b0;
  endtask
  task automatic sweep(input int k, input int l);
    int nacc = 0, nresp = 0, cyc = 0, last = 0, lat;
    logic a, r, er;
    logic [31:0] rd;
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b1;
    req_write[k]  = 1'b1;
    req_addr[k]   = 32'h40;
    req_be[k]     = 4'hF;
    req_wdata[k]  = 32'h100;
    while ((nacc < 6 || nresp < 6) && cyc < 400) begin
      a = req_valid[k] && req_ready[k];
      r = resp_valid[k] && resp_ready[k];
      tick;
      cyc++;
      if (r) nresp++;
      if (a) begin
        if (nacc > 0) chk($sformatf("accept_gap_L%0d", l), 32'(cyc - last), 32'(l + 2));
        last = cyc;
        nacc++;
        req_wdata[k] = 32'h100 + 32'(nacc);
        if (nacc == 6) req_valid[k] = 1'b0;
      end
    end
    resp_ready[k] = 1'b0;
    chk($sformatf("accepts_L%0d", l), 32'(nacc), 32'd6);
    chk($sformatf("responses_L%0d", l), 32'(nresp), 32'd6);
    op(k, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lat);
    chk($sformatf("sweep_last_store_L%0d", l), rd, 32'h105);
    chk($sformatf("sweep_latency_L%0d", l), 32'(lat), 32'(l));
    ack(k);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl [16];
    logic [31:0] rd;
    logic er;
    int lat;
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,       32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,       32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,       32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b0, 32'h22,       32'h0,        4'h0, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h3FC,      32'h01020304, 4'hF, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 32'h400,      32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h3FC,      32'h0,        4'h0, 32'h01020304, 1'b0};
    tbl[9]  = '{1'b1, 32'h10,       32'h12345678, 4'h0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[11] = '{1'b1, 32'h11,       32'h55555555, 4'hF, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[13] = '{1'b1, 32'h10,       32'h0000AA00, 4'h2, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 32'h10,       32'h0,        4'h0, 32'hDEADAAEF, 1'b0};
    tbl[15] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'h0,        1'b1};
    rst_n = '0; req_valid = '0; req_write = '0; resp_ready = '0;
    for (int k = 0; k < 4; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_be[k] = '0;
    end
    tick;
    tick;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_req_ready_%0d", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("reset_resp_valid_%0d", k), 32'(resp_valid[k]), 32'd0);
      chk($sformatf("reset_resp_rdata_%0d", k), resp_rdata[k], 32'd0);
      chk($sformatf("reset_resp_error_%0d", k), 32'(resp_error[k]), 32'd0);
    end
    rst_n = '1;
    tick;
    for (int i = 0; i < 16; i++) begin
      op(0, tbl[i].write, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_error", i), 32'(er), 32'(tbl[i].exp_err));
      ack(0);
      chk($sformatf("vec%0d_resp_cleared", i), 32'(resp_valid[0]), 32'd0);
    end
    // response held while the initiator stalls
    op(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold_resp_valid", 32'(resp_valid[0]), 32'd1);
      chk("hold_resp_rdata", resp_rdata[0], 32'h11BB33DD);
      chk("hold_resp_error", 32'(resp_error[0]), 32'd0);
      chk("hold_req_ready", 32'(req_ready[0]), 32'd0);
    end
    ack(0);
    chk("release_req_ready", 32'(req_ready[0]), 32'd1);
    chk("release_resp_valid", 32'(resp_valid[0]), 32'd0);
    chk("release_resp_rdata", resp_rdata[0], 32'd0);
    // reset during BUSY aborts the store; reset in RESP keeps it
    op(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, rd, er, lat);
    chk("l3_latency", 32'(lat), 32'd3);
    ack(1);
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h30;
    req_wdata[1] = 32'h0BADBEEF; req_be[1] = 4'hF;
    tick;
    req_valid[1] = 1'b0;
    tick;
    rst_n[1] = 1'b0;
    #1;
    chk("abort_req_ready", 32'(req_ready[1]), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("abort_resp_rdata", resp_rdata[1], 32'd0);
    chk("abort_resp_error", 32'(resp_error[1]), 32'd0);
    tick;
    rst_n[1] = 1'b1;
    tick;
    op(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("abort_old_value", rd, 32'hCAFEF00D);
    ack(1);
    op(1, 1'b1, 32'h30, 32'h0BADBEEF, 4'hF, rd, er, lat);
    rst_n[1] = 1'b0;
    #1;
    chk("resp_reset_valid", 32'(resp_valid[1]), 32'd0);
    tick;
    rst_n[1] = 1'b1;
    tick;
    op(1, 1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    chk("committed_store_kept", rd, 32'h0BADBEEF);
    ack(1);
    sweep(2, 1);
    sweep(3, 15);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
